// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among NUM_REQ requesters.
// A {valid, id} tag pipeline, matched to the multiplier depth, routes each product back to its owner.
module mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*16-1:0]      req_in0,
  input  logic [NUM_REQ*16-1:0]      req_in1,
  output logic [15:0]                mul_in0,
  output logic [15:0]                mul_in1,
  output logic                       mul_valid_in,
  input  logic [31:0]                mul_out,
  output logic                       resp_valid,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic [31:0]                resp_data
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0]     ptr;
  logic               grant_any;
  logic               grant;
  logic [IDW-1:0]     grant_id;
  logic [LATENCY-1:0] tag_v;
  logic [IDW-1:0]     tag_id [LATENCY];

  // Scan from the pointer upward, wrapping; the first asserted request wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = IDW'(idx);
      end
    end
  end

  // Reset gates the combinational outputs so they drop without waiting for a clock.
  assign grant = grant_any & ~reset;

  always_comb begin
    req_ready    = '0;
    mul_in0      = '0;
    mul_in1      = '0;
    mul_valid_in = 1'b0;
    if (grant) begin
      req_ready[grant_id] = 1'b1;
      mul_in0             = req_in0[grant_id*16 +: 16];
      mul_in1             = req_in1[grant_id*16 +: 16];
      mul_valid_in        = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      tag_v <= '0;
      for (int i = 0; i < LATENCY; i++) tag_id[i] <= '0;
    end else begin
      if (grant) ptr <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      tag_v[0]  <= grant;
      tag_id[0] <= grant_id;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  // The multiplier has no valid of its own; the tag pipeline alone qualifies mul_out.
  assign resp_valid = tag_v[LATENCY-1] & ~reset;
  assign resp_id    = resp_valid ? tag_id[LATENCY-1] : '0;
  assign resp_data  = resp_valid ? mul_out : '0;

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: a behavioural multiplier drives mul_out, and a
// queue-based reference model predicts grants and responses.
module tb_mul_arbiter;
  localparam int N   = 4;
  localparam int LAT = 2;
  localparam int IDW = $clog2(N);

  logic             clock = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*16-1:0]  req_in0, req_in1;
  logic [15:0]      mul_in0, mul_in1;
  logic             mul_valid_in;
  logic [31:0]      mul_out;
  logic             resp_valid;
  logic [IDW-1:0]   resp_id;
  logic [31:0]      resp_data;

  int n_checks = 0;
  int n_fail   = 0;

  mul_arbiter #(.NUM_REQ(N), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_in0(req_in0), .req_in1(req_in1), .mul_in0(mul_in0), .mul_in1(mul_in1),
    .mul_valid_in(mul_valid_in), .mul_out(mul_out), .resp_valid(resp_valid),
    .resp_id(resp_id), .resp_data(resp_data)
  );

  always #5 clock = ~clock;

  logic [31:0] mpipe [LAT];
  always @(posedge clock) begin
    mpipe[0] <= mul_in0 * mul_in1;
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_out = mpipe[LAT-1];

  // Reference model: rotating priority pointer plus a queue of responses due by cycle number.
  typedef struct { int cyc; int id; logic [31:0] data; } resp_t;
  resp_t rq[$];
  int    m_ptr = 0;
  int    cyc   = 0;

  function automatic int model_grant(logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N+32:0] exp_issue(int g);
    logic [N-1:0] oh = '0;
    if (g < 0) return '0;
    oh[g] = 1'b1;
    return {oh, 1'b1, req_in0[g*16 +: 16], req_in1[g*16 +: 16]};
  endfunction

  function automatic logic [IDW+32:0] exp_resp();
    if (rq.size() > 0 && rq[0].cyc == cyc) return {1'b1, IDW'(rq[0].id), rq[0].data};
    return '0;
  endfunction

  task automatic step(input int g);
    resp_t r;
    if (g >= 0) begin
      r.cyc  = cyc + LAT;
      r.id   = g;
      r.data = 32'(req_in0[g*16 +: 16]) * 32'(req_in1[g*16 +: 16]);
    end
    @(posedge clock);
    while (rq.size() > 0 && rq[0].cyc <= cyc) void'(rq.pop_front());
    if (g >= 0) begin
      rq.push_back(r);
      m_ptr = (g + 1) % N;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    @(posedge clock);
    #1;
    rq.delete();
    m_ptr = 0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = '1;
    for (int i = 0; i < N; i++) begin
      req_in0[i*16 +: 16] = 16'($urandom);
      req_in1[i*16 +: 16] = 16'($urandom);
    end
    repeat (2) @(posedge clock);
    #2;
    n_checks++;
    if ({req_ready, mul_valid_in, mul_in0, mul_in1, resp_valid, resp_id, resp_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b mv=%b in0=%h in1=%h rv=%b id=%0d d=%h, want all 0",
               req_ready, mul_valid_in, mul_in0, mul_in1, resp_valid, resp_id, resp_data);
    end
    req_valid = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    rq.delete();
    m_ptr = 0;
    #2;
    n_checks++;
    if ({req_ready, mul_valid_in, resp_valid, resp_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: got rdy=%b mv=%b rv=%b d=%h, want all 0",
               req_ready, mul_valid_in, resp_valid, resp_data);
    end
    step(-1);
  endtask

  task automatic test_single();
    int g;
    req_in0 = '0; req_in1 = '0;
    req_in0[15:0] = 16'd3;
    req_in1[15:0] = 16'd5;
    for (int c = 0; c < 5; c++) begin
      req_valid = (c == 0) ? 4'b0001 : 4'b0000;
      #2;
      g = model_grant(req_valid);
      n_checks++;
      if ({req_ready, mul_valid_in, mul_in0, mul_in1} !== exp_issue(g)) begin
        n_fail++;
        $display("FAIL single_issue c%0d: got %h want %h", c, {req_ready, mul_valid_in, mul_in0, mul_in1}, exp_issue(g));
      end
      n_checks++;
      if ({resp_valid, resp_id, resp_data} !== exp_resp()) begin
        n_fail++;
        $display("FAIL single_resp c%0d: got %h want %h", c, {resp_valid, resp_id, resp_data}, exp_resp());
      end
      if (c == LAT) begin
        n_checks++;
        if (resp_data !== 32'd15) begin
          n_fail++;
          $display("FAIL single_product: got %0d want 15", resp_data);
        end
      end
      step(g);
    end
  endtask

  task automatic test_round_robin();
    int g;
    logic [N-1:0] exp_oh;
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_in0[i*16 +: 16] = 16'($urandom);
      req_in1[i*16 +: 16] = 16'($urandom);
    end
    for (int c = 0; c < 8 + LAT; c++) begin
      req_valid = (c < 8) ? '1 : '0;
      #2;
      g = model_grant(req_valid);
      n_checks++;
      if ({req_ready, mul_valid_in, mul_in0, mul_in1} !== exp_issue(g)) begin
        n_fail++;
        $display("FAIL rr_issue c%0d: got %h want %h", c, {req_ready, mul_valid_in, mul_in0, mul_in1}, exp_issue(g));
      end
      n_checks++;
      if ({resp_valid, resp_id, resp_data} !== exp_resp()) begin
        n_fail++;
        $display("FAIL rr_resp c%0d: got %h want %h", c, {resp_valid, resp_id, resp_data}, exp_resp());
      end
      if (c < 8) begin
        exp_oh = 4'b0001 << (c % N);
        n_checks++;
        if (req_ready !== exp_oh) begin
          n_fail++;
          $display("FAIL rr_order c%0d: got %b want %b", c, req_ready, exp_oh);
        end
      end
      step(g);
      if (g >= 0) begin
        req_in0[g*16 +: 16] = 16'($urandom);
        req_in1[g*16 +: 16] = 16'($urandom);
      end
    end
  endtask

  task automatic test_max_operands();
    int g;
    req_in0 = '0; req_in1 = '0;
    req_in0[2*16 +: 16] = 16'hFFFF;
    req_in1[2*16 +: 16] = 16'hFFFF;
    for (int c = 0; c < LAT + 1; c++) begin
      req_valid = (c == 0) ? 4'b0100 : 4'b0000;
      #2;
      g = model_grant(req_valid);
      n_checks++;
      if ({req_ready, mul_valid_in, mul_in0, mul_in1} !== exp_issue(g)) begin
        n_fail++;
        $display("FAIL max_issue c%0d: got %h want %h", c, {req_ready, mul_valid_in, mul_in0, mul_in1}, exp_issue(g));
      end
      n_checks++;
      if ({resp_valid, resp_id, resp_data} !== exp_resp()) begin
        n_fail++;
        $display("FAIL max_resp c%0d: got %h want %h", c, {resp_valid, resp_id, resp_data}, exp_resp());
      end
      if (c == LAT) begin
        n_checks++;
        if (resp_data !== 32'hFFFE0001) begin
          n_fail++;
          $display("FAIL max_product: got %h want fffe0001", resp_data);
        end
      end
      step(g);
    end
  endtask

  task automatic test_wrap();
    int g;
    logic [N-1:0] vt [6];
    vt = '{4'b0100, 4'b1001, 4'b0001, 4'b0011, 4'b0000, 4'b0000};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      req_valid = vt[c];
      for (int i = 0; i < N; i++) begin
        req_in0[i*16 +: 16] = 16'($urandom);
        req_in1[i*16 +: 16] = 16'($urandom);
      end
      #2;
      g = model_grant(req_valid);
      n_checks++;
      if ({req_ready, mul_valid_in, mul_in0, mul_in1} !== exp_issue(g)) begin
        n_fail++;
        $display("FAIL wrap_issue c%0d: got %h want %h", c, {req_ready, mul_valid_in, mul_in0, mul_in1}, exp_issue(g));
      end
      n_checks++;
      if ({resp_valid, resp_id, resp_data} !== exp_resp()) begin
        n_fail++;
        $display("FAIL wrap_resp c%0d: got %h want %h", c, {resp_valid, resp_id, resp_data}, exp_resp());
      end
      step(g);
    end
  endtask

  task automatic test_sparse();
    int g;
    logic [N-1:0] vt [7];
    vt = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      req_valid = vt[c];
      for (int i = 0; i < N; i++) begin
        req_in0[i*16 +: 16] = 16'($urandom);
        req_in1[i*16 +: 16] = 16'($urandom);
      end
      #2;
      g = model_grant(req_valid);
      n_checks++;
      if ({req_ready, mul_valid_in, mul_in0, mul_in1} !== exp_issue(g)) begin
        n_fail++;
        $display("FAIL sparse_issue c%0d: got %h want %h", c, {req_ready, mul_valid_in, mul_in0, mul_in1}, exp_issue(g));
      end
      n_checks++;
      if ({resp_valid, resp_id, resp_data} !== exp_resp()) begin
        n_fail++;
        $display("FAIL sparse_resp c%0d: got %h want %h", c, {resp_valid, resp_id, resp_data}, exp_resp());
      end
      step(g);
    end
  endtask

  task automatic test_reset_mid();
    int g;
    do_reset();
    req_valid = 4'b0100;
    req_in0[2*16 +: 16] = 16'($urandom);
    req_in1[2*16 +: 16] = 16'($urandom);
    #2;
    g = model_grant(req_valid);
    n_checks++;
    if ({req_ready, mul_valid_in, mul_in0, mul_in1} !== exp_issue(g)) begin
      n_fail++;
      $display("FAIL midrst_issue: got %h want %h", {req_ready, mul_valid_in, mul_in0, mul_in1}, exp_issue(g));
    end
    step(g);
    req_valid = '0;
    #1;
    reset     = 1'b1;
    req_valid = '1;
    #1;
    n_checks++;
    if ({req_ready, mul_valid_in, mul_in0, mul_in1, resp_valid, resp_id, resp_data} !== '0) begin
      n_fail++;
      $display("FAIL midrst_async: got rdy=%b mv=%b rv=%b d=%h, want all 0",
               req_ready, mul_valid_in, resp_valid, resp_data);
    end
    req_valid = '0;
    rq.delete();
    m_ptr = 0;
    @(negedge clock);
    #1;
    reset = 1'b0;
    step(-1);
    for (int c = 0; c < 2 + LAT; c++) begin
      req_valid = (c == 1) ? 4'b1010 : 4'b0000;
      for (int i = 0; i < N; i++) begin
        req_in0[i*16 +: 16] = 16'($urandom);
        req_in1[i*16 +: 16] = 16'($urandom);
      end
      #2;
      g = model_grant(req_valid);
      n_checks++;
      if ({req_ready, mul_valid_in, mul_in0, mul_in1} !== exp_issue(g)) begin
        n_fail++;
        $display("FAIL midrst_post_issue c%0d: got %h want %h", c, {req_ready, mul_valid_in, mul_in0, mul_in1}, exp_issue(g));
      end
      n_checks++;
      if ({resp_valid, resp_id, resp_data} !== exp_resp()) begin
        n_fail++;
        $display("FAIL midrst_post_resp c%0d: got %h want %h", c, {resp_valid, resp_id, resp_data}, exp_resp());
      end
      step(g);
    end
  endtask

  task automatic test_random();
    int g;
    bit          pv [N];
    logic [15:0] pa [N];
    logic [15:0] pb [N];
    int          wc [N];
    for (int i = 0; i < N; i++) begin pv[i] = 1'b0; wc[i] = 0; pa[i] = '0; pb[i] = '0; end
    for (int c = 0; c < 300 + LAT + 1; c++) begin
      for (int i = 0; i < N; i++) begin
        if (c < 300 && !pv[i] && $urandom_range(0, 1) == 1) begin
          pv[i] = 1'b1;
          wc[i] = 0;
          pa[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
          pb[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        end
        req_valid[i]        = pv[i];
        req_in0[i*16 +: 16] = pa[i];
        req_in1[i*16 +: 16] = pb[i];
      end
      #2;
      g = model_grant(req_valid);
      n_checks++;
      if ({req_ready, mul_valid_in, mul_in0, mul_in1} !== exp_issue(g)) begin
        n_fail++;
        $display("FAIL rand_issue c%0d: got %h want %h", c, {req_ready, mul_valid_in, mul_in0, mul_in1}, exp_issue(g));
      end
      n_checks++;
      if ({resp_valid, resp_id, resp_data} !== exp_resp()) begin
        n_fail++;
        $display("FAIL rand_resp c%0d: got %h want %h", c, {resp_valid, resp_id, resp_data}, exp_resp());
      end
      for (int i = 0; i < N; i++) begin
        if (pv[i]) begin
          if (req_ready[i] === 1'b1) pv[i] = 1'b0;
          else begin
            wc[i]++;
            n_checks++;
            if (wc[i] >= N) begin
              n_fail++;
              $display("FAIL fairness req%0d c%0d: waited %0d cycles, limit %0d", i, c, wc[i], N - 1);
            end
          end
        end
      end
      step(g);
    end
  endtask

  initial begin
    req_valid = '0;
    req_in0   = '0;
    req_in1   = '0;
    reset     = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_max_operands();
    test_wrap();
    test_sparse();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
